// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus the 2**ADDR_W x DATA_W architectural
// register file. It selects the write-back data, commits it on the rising
// edge, serves two combinational ID-stage read ports with optional same-cycle
// bypass, and keeps a 32-bit count of committed register writes.
//
// Handshake: there is no valid/ready pair. The MEM/WB register presents one
// instruction every cycle. wb_RegWrite acts as the "valid" qualifier for a
// write, and the file is always ready, so a write that is qualified commits
// on that same rising edge.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_RegWrite,
    input  logic              wb_MemToReg,
    input  logic [DATA_W-1:0] MemWb_ReadData,
    input  logic [DATA_W-1:0] MemWb_AluResult,
    input  logic [ADDR_W-1:0] MemWb_MuxRegDst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] Wb_WriteData,
    output logic [ADDR_W-1:0] Wb_WriteReg,
    output logic              Wb_WriteEn,
    output logic [31:0]       Wb_CommitCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [31:0]       commit_count;

    // Write-back mux, export of the destination, and the effective write
    // enable. r0 is hardwired to zero and reset blocks the write.
    always_comb begin
        Wb_WriteData = wb_MemToReg ? MemWb_ReadData : MemWb_AluResult;
        Wb_WriteReg  = MemWb_MuxRegDst;
        Wb_WriteEn   = wb_RegWrite && (MemWb_MuxRegDst != '0) && !reset;
    end

    // Register storage and commit counter. Reset clears the whole file in a
    // single edge and takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            commit_count <= '0;
        end else if (Wb_WriteEn) begin
            regs[MemWb_MuxRegDst] <= Wb_WriteData;
            commit_count          <= commit_count + 32'd1;
        end
    end

    assign Wb_CommitCount = commit_count;

    // Read port 1. r0 and reset read as zero. The in-flight write is returned
    // first (write-first), otherwise the stored value is returned.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (reset || (ReadReg1 == '0)) begin
            ReadData1 = '0;
        end else if (BYPASS && Wb_WriteEn && (ReadReg1 == MemWb_MuxRegDst)) begin
            ReadData1 = Wb_WriteData;
        end
    end

    // Read port 2. Same rules as port 1 and fully independent of it.
    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (reset || (ReadReg2 == '0)) begin
            ReadData2 = '0;
        end else if (BYPASS && Wb_WriteEn && (ReadReg2 == MemWb_MuxRegDst)) begin
            ReadData2 = Wb_WriteData;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile. The driver applies one MEM/WB slot per cycle on
// the falling edge. For each slot it computes the expected outputs from an
// array model of the register file and queues them. A separate monitor
// samples the DUT shortly before the next rising edge and compares the
// sample against the head of the queue.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int HALF   = 5;
    // Packed expectation: {rd1, rd2, wdata, wreg, we, count}
    localparam int EXP_W  = 32 + 32 + 32 + 5 + 1 + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_RegWrite;
    logic              wb_MemToReg;
    logic [DATA_W-1:0] MemWb_ReadData;
    logic [DATA_W-1:0] MemWb_AluResult;
    logic [ADDR_W-1:0] MemWb_MuxRegDst;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] Wb_WriteData;
    logic [ADDR_W-1:0] Wb_WriteReg;
    logic              Wb_WriteEn;
    logic [31:0]       Wb_CommitCount;

    // Scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    bit               drv_valid = 1'b0;
    bit               stim_done = 1'b0;
    int               tests_run = 0;
    int               tests_failed = 0;
    int               cycle_no = 0;

    // Reference model: architectural contents and the number of writes so far
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    wb_regfile #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_RegWrite    (wb_RegWrite),
        .wb_MemToReg    (wb_MemToReg),
        .MemWb_ReadData (MemWb_ReadData),
        .MemWb_AluResult(MemWb_AluResult),
        .MemWb_MuxRegDst(MemWb_MuxRegDst),
        .ReadReg1       (ReadReg1),
        .ReadReg2       (ReadReg2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .Wb_WriteData   (Wb_WriteData),
        .Wb_WriteReg    (Wb_WriteReg),
        .Wb_WriteEn     (Wb_WriteEn),
        .Wb_CommitCount (Wb_CommitCount)
    );

    // Clock
    always #HALF clk = ~clk;

    // The value an architectural read must see during this slot
    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit rst,
                                               input bit we, input logic [4:0] dst,
                                               input logic [31:0] wd);
        if (rst || idx == 5'd0) return 32'd0;
        if (we && idx == dst)   return wd;
        return m_regs[idx];
    endfunction

    // Driver: applies one slot, queues its expectation, then advances the model
    // across the coming rising edge.
    task automatic drive(input bit rst, input bit rw, input bit m2r,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [4:0] dst, input logic [4:0] r1,
                         input logic [4:0] r2, input bit chk);
        logic [31:0] wd;
        bit          we;
        @(negedge clk);
        reset           = rst;
        wb_RegWrite     = rw;
        wb_MemToReg     = m2r;
        MemWb_ReadData  = rdata;
        MemWb_AluResult = alu;
        MemWb_MuxRegDst = dst;
        ReadReg1        = r1;
        ReadReg2        = r2;
        wd = m2r ? rdata : alu;
        we = rw && (dst != 5'd0) && !rst;
        if (chk) begin
            exp_q.push_back({model_read(r1, rst, we, dst, wd),
                             model_read(r2, rst, we, dst, wd),
                             wd, dst, we, m_count});
        end
        drv_valid = chk;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_count = 32'd0;
        end else if (we) begin
            m_regs[dst] = wd;
            m_count     = m_count + 32'd1;
        end
    endtask

    task automatic check_field(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle_no, got, exp);
        end
    endtask

    // Monitor: compares the DUT against the head of the queue before each rising edge
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            #(HALF - 2);
            cycle_no++;
            if (drv_valid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL scoreboard_underflow cycle=%0d got=empty expected=entry", cycle_no);
                end else begin
                    e = exp_q.pop_front();
                    check_field("ReadData1",      ReadData1,               e[133:102]);
                    check_field("ReadData2",      ReadData2,               e[101:70]);
                    check_field("Wb_WriteData",   Wb_WriteData,            e[69:38]);
                    check_field("Wb_WriteReg",    {27'd0, Wb_WriteReg},    {27'd0, e[37:33]});
                    check_field("Wb_WriteEn",     {31'd0, Wb_WriteEn},     {31'd0, e[32]});
                    check_field("Wb_CommitCount", Wb_CommitCount,          e[31:0]);
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized traffic
    initial begin
        logic [4:0]  dst, r1, r2;
        bit          rst;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;

        // Power-up reset: DUT state is unknown before this edge, so do not check it.
        drive(1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0);
        drive(1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1);

        // All indices read zero on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i), 1);
        end

        // ALU write to r8, with a same-cycle bypass and a read from storage afterwards.
        drive(0, 1, 0, 32'h0, 32'h0000_1234, 5'd8, 5'd8, 5'd0, 1);
        drive(0, 0, 0, 32'h0, 32'h0,         5'd8, 5'd8, 5'd8, 1);

        // Memory data aimed at r0 is discarded.
        drive(0, 1, 1, 32'hDEAD_BEEF, 32'h1, 5'd0, 5'd0, 5'd0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0, 1);

        // Back-to-back writes to r5 with both ports watching.
        drive(0, 1, 0, 32'h0, 32'hA, 5'd5, 5'd5, 5'd5, 1);
        drive(0, 1, 0, 32'h0, 32'hB, 5'd5, 5'd5, 5'd5, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, 1);

        // A write coincident with reset is lost, and reads are forced to zero during reset.
        drive(1, 1, 0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd8, 1);
        drive(0, 0, 0, 32'h0, 32'h0,  5'd3, 5'd3, 5'd8, 1);
        drive(0, 1, 1, 32'h77, 32'h0, 5'd3, 5'd3, 5'd3, 1);
        drive(0, 0, 0, 32'h0, 32'h0,  5'd0, 5'd3, 5'd5, 1);

        // Randomized traffic, biased toward a few registers to exercise bypass.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            dst = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 3));
            drive(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, dst, r1, r2, 1);
        end

        @(negedge clk);
        drv_valid = 1'b0;
        stim_done = 1'b1;
    end

    // Final report: bounded wait for the scoreboard to drain
    initial begin
        wait (stim_done);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0 pending", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Overall time limit so the run always ends on its own
    initial begin
        #(HALF * 2 * 5000);
        tests_failed++;
        $display("FAIL time_limit got=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
